mm_timer: RTL and testbench
===========================

Name: mm_timer

Overview:
- Memory-mapped 16-bit timer peripheral that acts as the responder on the CPU data-memory bus (addr/wdata/rdata/mm_we/mm_re).
- Decodes a small register window and returns read data combinationally in the same cycle.
- Counts prescaled clock ticks and raises a match flag/interrupt when the count equals a programmable compare value.
- Sits beside data memory; its rdata is OR-combined with the other responders.

Parameters:
BASE_ADDR, 16'hC000, window base; must be 8-word aligned (bits [2:0] = 0)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
addr  input  16  word address from CPU
wdata  input  16  write data from CPU
mm_we  input  1  write strobe, sampled at posedge clk
mm_re  input  1  read strobe
rdata  output  16  read data; 16'h0000 when not selected
irq  output  1  interrupt request, level, = flag & CTRL[2]

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Select: sel = (addr[15:3] == BASE_ADDR[15:3]). Offsets are addr[2:0].
- Register map:
  - 0 CTRL [2:0] R/W: bit0 EN, bit1 AUTO (auto-reload), bit2 IE.
  - 1 PRESCALE [15:0] R/W.
  - 2 COUNT [15:0] R/W.
  - 3 COMPARE [15:0] R/W.
  - 4 STATUS bit0 FLAG: read returns FLAG; writing 1 clears it, writing 0 has no effect.
  - 5–7: read 0, writes ignored.
  - Unused CTRL/STATUS bits read 0.
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=16'hFFFF, FLAG=0, internal prescale counter pc=0. Outputs rdata=0, irq=0.
- Read path: rdata = (sel & mm_re) ? reg[offset] : 16'h0000. It is combinational, with zero latency and no read side effects. Simultaneous mm_re and mm_we reads the pre-write value.
- Writes: take effect at the posedge where sel & mm_we. Reads see the new value from the next cycle.
- Prescaler:
  - When EN=1, each cycle: if pc == PRESCALE then pc<=0 and a tick occurs; else pc<=pc+1.
  - When EN=0, pc holds.
  - Any write to PRESCALE or CTRL resets pc to 0.
  - Tick period is PRESCALE+1 cycles.
- Tick action, when COUNT == COMPARE:
  - FLAG<=1.
  - If AUTO=1: COUNT<=0.
  - If AUTO=0: COUNT<=COUNT+1 and EN<=0 (one-shot stop).
- Tick action, otherwise: COUNT<=COUNT+1, wrapping 16'hFFFF->16'h0000 with no flag.
- Timing: the first tick occurs at the edge after the edge that writes EN=1, when PRESCALE=0.
- Priority and simultaneous events:
  - A CPU write to COUNT in the same cycle as a tick: the write wins, and the tick's increment and reload are discarded. The match test still uses the old COUNT, so FLAG may still set.
  - A CPU write to CTRL in the same cycle as a one-shot clear: the CPU write wins.
  - STATUS write-1-clear in the same cycle as FLAG set: set wins (FLAG=1).
- COMPARE write: takes effect for ticks from the next cycle. A COMPARE value below COUNT matches only after wrap.
- irq: combinational from registered state (FLAG & IE), so it is glitch-free relative to the bus.
- Reset mid-count: all state returns to reset values immediately and asynchronously; there are no pending ticks after deassertion.
- Sizing: 5 registers, one 16-bit prescale counter, and decode/mux, 120–250 lines.

Test Plan:
1. Reset/read-back: after reset, read offsets 0–7 at BASE_ADDR -> 0,0,0,FFFF,0,0,0,0. Read addr 16'hC008 -> rdata=0. irq=0.
2. Basic count: PRESCALE=0, COMPARE=5, CTRL=3'b111 -> COUNT goes 1..5 on successive edges.
   - The tick at COUNT==5 sets FLAG and reloads COUNT to 0; irq=1.
   - Write STATUS=1 -> FLAG=0, irq=0.
3. Prescale/one-shot: PRESCALE=3, COMPARE=2, CTRL=3'b001 -> COUNT increments every 4 cycles.
   - The match after 12 cycles sets FLAG, COUNT=3, EN=0, and the count then holds.
   - irq stays 0 because IE=0.
4. Wrap: COUNT=16'hFFFE, COMPARE=16'h0001, PRESCALE=0, EN=1, AUTO=1 -> COUNT sequence FFFF, 0000, 0001, then 0000 with FLAG=1.
5. Collisions:
   - COUNT write of 16'h0100 coincident with a tick -> COUNT=16'h0100.
   - STATUS clear coincident with a match -> FLAG remains 1.
6. Async reset mid-count: assert rst_n=0 between edges while COUNT=4 -> COUNT, FLAG, irq and rdata go to 0 immediately. After release, there are no ticks until EN is rewritten.

Source files
------------

// File: rtl/mm_timer_if.sv
// CPU data-memory bus as seen by the timer: word address, write data, strobes,
// read data back and the level interrupt.
interface mm_timer_if;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        mm_we;
   logic        mm_re;
   logic [15:0] rdata;
   logic        irq;

   modport master (
      output addr,
      output wdata,
      output mm_we,
      output mm_re,
      input  rdata,
      input  irq
   );

   modport slave (
      input  addr,
      input  wdata,
      input  mm_we,
      input  mm_re,
      output rdata,
      output irq
   );
endinterface

// File: rtl/mm_timer.sv
// Memory-mapped 16-bit timer: prescaled counter with a compare match flag,
// optional auto-reload or one-shot stop, and a level interrupt.
module mm_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hC000
) (
   input  logic      clk,
   input  logic      rst_n,
   mm_timer_if.slave bus
);

   localparam logic [2:0] OffCtrl     = 3'd0;
   localparam logic [2:0] OffPrescale = 3'd1;
   localparam logic [2:0] OffCount    = 3'd2;
   localparam logic [2:0] OffCompare  = 3'd3;
   localparam logic [2:0] OffStatus   = 3'd4;

   if (BASE_ADDR[2:0] != 3'b000) begin : g_bad_base
      $error("mm_timer: BASE_ADDR must be 8-word aligned");
   end

   // CTRL bit positions
   localparam int unsigned BitEn   = 0;
   localparam int unsigned BitAuto = 1;
   localparam int unsigned BitIe   = 2;

   logic [2:0]  ctrl_q,     ctrl_d;
   logic [15:0] prescale_q, prescale_d;
   logic [15:0] count_q,    count_d;
   logic [15:0] compare_q,  compare_d;
   logic        flag_q,     flag_d;
   logic [15:0] pc_q,       pc_d;

   logic        sel;
   logic [2:0]  off;
   logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
   logic        tick;
   logic        match;
   logic [15:0] rdata_mux;

   assign sel = (bus.addr[15:3] == BASE_ADDR[15:3]);
   assign off = bus.addr[2:0];

   always_comb begin
      wr_ctrl     = 1'b0;
      wr_prescale = 1'b0;
      wr_count    = 1'b0;
      wr_compare  = 1'b0;
      wr_status   = 1'b0;
      if (sel && bus.mm_we) begin
         case (off)
            OffCtrl:     wr_ctrl     = 1'b1;
            OffPrescale: wr_prescale = 1'b1;
            OffCount:    wr_count    = 1'b1;
            OffCompare:  wr_compare  = 1'b1;
            OffStatus:   wr_status   = 1'b1;
            default:     ;
         endcase
      end
   end

   assign tick  = ctrl_q[BitEn] && (pc_q == prescale_q);
   assign match = tick && (count_q == compare_q);

   // CPU writes are applied last so they override same-cycle timer updates,
   // except the flag, where a match beats a write-1-clear.
   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      count_d    = count_q;
      compare_d  = compare_q;
      flag_d     = flag_q;
      pc_d       = pc_q;

      if (ctrl_q[BitEn]) begin
         pc_d = tick ? 16'h0000 : pc_q + 16'd1;
      end

      if (tick) begin
         if (match && ctrl_q[BitAuto]) begin
            count_d = 16'h0000;
         end else begin
            count_d = count_q + 16'd1;
         end
         if (match && !ctrl_q[BitAuto]) begin
            ctrl_d[BitEn] = 1'b0;
         end
      end

      if (wr_status && bus.wdata[0]) begin
         flag_d = 1'b0;
      end
      if (match) begin
         flag_d = 1'b1;
      end

      if (wr_ctrl) begin
         ctrl_d = bus.wdata[2:0];
         pc_d   = 16'h0000;
      end
      if (wr_prescale) begin
         prescale_d = bus.wdata;
         pc_d       = 16'h0000;
      end
      if (wr_count) begin
         count_d = bus.wdata;
      end
      if (wr_compare) begin
         compare_d = bus.wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= 3'b000;
         prescale_q <= 16'h0000;
         count_q    <= 16'h0000;
         compare_q  <= 16'hFFFF;
         flag_q     <= 1'b0;
         pc_q       <= 16'h0000;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         flag_q     <= flag_d;
         pc_q       <= pc_d;
      end
   end

   always_comb begin
      rdata_mux = 16'h0000;
      if (sel && bus.mm_re) begin
         case (off)
            OffCtrl:     rdata_mux = {13'd0, ctrl_q};
            OffPrescale: rdata_mux = prescale_q;
            OffCount:    rdata_mux = count_q;
            OffCompare:  rdata_mux = compare_q;
            OffStatus:   rdata_mux = {15'd0, flag_q};
            default:     rdata_mux = 16'h0000;
         endcase
      end
   end

   assign bus.rdata = rdata_mux;
   assign bus.irq   = flag_q & ctrl_q[BitIe];

endmodule

// File: tb/tb_mm_timer.sv
// Directed bench for mm_timer: expectations are queued as each step is driven
// and popped when the bus output is sampled.
module tb_mm_timer;

   localparam logic [15:0] Base       = 16'hC000;
   localparam logic [15:0] ACtrl      = Base + 16'd0;
   localparam logic [15:0] APrescale  = Base + 16'd1;
   localparam logic [15:0] ACount     = Base + 16'd2;
   localparam logic [15:0] ACompare   = Base + 16'd3;
   localparam logic [15:0] AStatus    = Base + 16'd4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [15:0] exp_q[$];

   mm_timer_if bus ();

   mm_timer #(
      .BASE_ADDR(Base)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic sb_check(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s scoreboard empty observed=%h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Write lands on the next posedge; returns 1 time unit after it.
   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.mm_we = 1'b1;
      bus.mm_re = 1'b0;
      @(posedge clk);
      #1;
      bus.mm_we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] e, input string tag);
      exp_q.push_back(e);
      bus.addr  = a;
      bus.mm_we = 1'b0;
      bus.mm_re = 1'b1;
      #1;
      sb_check(tag, bus.rdata);
      bus.mm_re = 1'b0;
   endtask

   task automatic chk_irq(input logic e, input string tag);
      exp_q.push_back({15'd0, e});
      #0;
      sb_check(tag, {15'd0, bus.irq});
   endtask

   logic [15:0] rst_vals [8];

   initial begin
      total = 0;
      bad   = 0;
      rst_vals = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000};
      bus.addr  = 16'h0000;
      bus.wdata = 16'h0000;
      bus.mm_we = 1'b0;
      bus.mm_re = 1'b0;
      rst_n     = 1'b0;
      #25;
      rst_n = 1'b1;
      step(1);

      // Reset state and read-back
      for (int i = 0; i < 8; i++) begin
         rd(Base + 16'(i), rst_vals[i], $sformatf("reset_off%0d", i));
      end
      step(1);
      rd(16'hC008, 16'h0000, "unselected_read");
      exp_q.push_back(16'h0000);
      bus.addr  = ACount;
      bus.mm_re = 1'b0;
      #1;
      sb_check("no_re_read", bus.rdata);
      chk_irq(1'b0, "reset_irq");

      // Basic auto-reload count with interrupt
      wr(APrescale, 16'd0);
      wr(ACompare, 16'd5);
      wr(ACtrl, 16'h0007);
      rd(ACount, 16'd0, "basic_start");
      for (int i = 1; i <= 5; i++) begin
         step(1);
         rd(ACount, 16'(i), $sformatf("basic_count%0d", i));
      end
      rd(AStatus, 16'd0, "basic_noflag");
      step(1);
      rd(ACount, 16'd0, "basic_reload");
      rd(AStatus, 16'd1, "basic_flag");
      chk_irq(1'b1, "basic_irq");
      wr(AStatus, 16'h0001);
      rd(AStatus, 16'd0, "basic_clear");
      chk_irq(1'b0, "basic_irq_clear");
      rd(ACount, 16'd1, "basic_continue");

      // Prescaled one-shot
      wr(ACtrl, 16'h0000);
      wr(AStatus, 16'h0001);
      wr(ACount, 16'd0);
      wr(APrescale, 16'd3);
      wr(ACompare, 16'd2);
      wr(ACtrl, 16'h0001);
      for (int c = 1; c <= 12; c++) begin
         step(1);
         rd(ACount, (c >= 12) ? 16'd3 : 16'(c / 4), $sformatf("oneshot_c%0d", c));
      end
      rd(AStatus, 16'd1, "oneshot_flag");
      rd(ACtrl, 16'd0, "oneshot_en_clear");
      chk_irq(1'b0, "oneshot_irq_masked");
      step(9);
      rd(ACount, 16'd3, "oneshot_hold");

      // Wrap through 16'hFFFF
      wr(AStatus, 16'h0001);
      wr(APrescale, 16'd0);
      wr(ACompare, 16'h0001);
      wr(ACount, 16'hFFFE);
      wr(ACtrl, 16'h0003);
      step(1);
      rd(ACount, 16'hFFFF, "wrap_ffff");
      step(1);
      rd(ACount, 16'h0000, "wrap_0000");
      rd(AStatus, 16'd0, "wrap_noflag");
      step(1);
      rd(ACount, 16'h0001, "wrap_0001");
      step(1);
      rd(ACount, 16'h0000, "wrap_reload");
      rd(AStatus, 16'd1, "wrap_flag");

      // Collisions: COUNT write beats tick; match beats STATUS clear
      wr(ACount, 16'h0100);
      rd(ACount, 16'h0100, "coll_count_write");
      wr(ACtrl, 16'h0000);
      wr(AStatus, 16'h0001);
      wr(ACompare, 16'd5);
      wr(ACount, 16'd4);
      wr(ACtrl, 16'h0003);
      step(1);
      rd(ACount, 16'd5, "coll_pre_match");
      rd(AStatus, 16'd0, "coll_pre_flag");
      wr(AStatus, 16'h0001);
      rd(AStatus, 16'd1, "coll_flag_set_wins");
      rd(ACount, 16'd0, "coll_reload");

      // Asynchronous reset mid-count with FLAG and IE set
      wr(ACtrl, 16'h0000);
      wr(APrescale, 16'd3);
      wr(ACompare, 16'hFFFF);
      wr(ACount, 16'd4);
      wr(ACtrl, 16'h0007);
      rd(ACount, 16'd4, "prerst_count");
      chk_irq(1'b1, "prerst_irq");
      exp_q.push_back(16'h0000);
      bus.addr  = ACount;
      bus.mm_re = 1'b1;
      rst_n     = 1'b0;
      #1;
      sb_check("rst_count", bus.rdata);
      bus.mm_re = 1'b0;
      chk_irq(1'b0, "rst_irq");
      rd(AStatus, 16'd0, "rst_flag");
      #1;
      rst_n = 1'b1;
      step(10);
      rd(ACount, 16'd0, "post_rst_no_tick");
      rd(ACtrl, 16'd0, "post_rst_ctrl");
      rd(ACompare, 16'hFFFF, "post_rst_compare");
      wr(ACtrl, 16'h0001);
      step(1);
      rd(ACount, 16'd1, "post_rst_rearm");

      if (exp_q.size() != 0) begin
         bad++;
         $error("FAIL leftover_expectations observed=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
